// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Owns the fetch PC, issues one
//               outstanding request at a time to instruction memory, buffers
//               returned {pc,inst} pairs in a small FIFO and presents the head
//               to the IF/ID register. Handles stalls and redirects, dropping
//               wrong-path responses.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter int                         INST_WIDTH      = 32,
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter int                         BUF_DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_valid,
    output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                       imem_req_ready,
    input  logic                       imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]      imem_rsp_inst,
    input  logic                       stall_IF,
    input  logic                       redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       valid_IF,
    output logic [INST_WIDTH-1:0]      INST_IF,
    output logic [INST_ADDR_WIDTH-1:0] PC_IF,
    output logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF
);

    localparam int                         c_PTR_W    = $clog2(BUF_DEPTH);
    localparam logic [c_PTR_W:0]           c_DEPTH    = (c_PTR_W+1)'(BUF_DEPTH);
    localparam logic [c_PTR_W:0]           c_CNT_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0]         c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [INST_ADDR_WIDTH-1:0] c_PC_STEP  = INST_ADDR_WIDTH'(4);
    localparam logic [INST_ADDR_WIDTH-1:0] c_ALIGN    = ~(INST_ADDR_WIDTH'(3));
    localparam logic [INST_WIDTH-1:0]      c_NOP      = INST_WIDTH'(32'h0000_0013);

    // IDLE: nothing outstanding; WAIT: useful response pending;
    // DROP: wrong-path response pending, to be discarded.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [INST_ADDR_WIDTH-1:0] r_fetch_pc;
    logic [INST_ADDR_WIDTH-1:0] r_req_pc;
    logic [INST_ADDR_WIDTH-1:0] r_buf_pc   [BUF_DEPTH];
    logic [INST_WIDTH-1:0]      r_buf_inst [BUF_DEPTH];
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_PTR_W:0]           r_count;
    logic                       w_empty;
    logic                       w_req_fire;
    logic                       w_push;
    logic                       w_pop;

    assign w_empty       = (r_count == '0);
    assign imem_req_addr = r_fetch_pc;
    assign w_req_fire    = imem_req_valid && imem_req_ready;
    // A response arriving with a redirect belongs to the old path: never buffered.
    assign w_push        = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_pop         = valid_IF && !stall_IF && !redirect_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and request issue; a request is only raised while a FIFO slot is free.
    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                imem_req_valid = (r_count < c_DEPTH) && !redirect_valid && !rst;
                if (imem_req_valid && imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (redirect_valid) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fetch PC and the PC of the request in flight; redirect takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & c_ALIGN;
        end else if (w_req_fire) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + c_PC_STEP;
        end
    end

    // FIFO pointers and occupancy; a redirect flushes the buffer.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // FIFO storage; contents are qualified by the occupancy count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
            r_buf_inst[r_wr_ptr] <= imem_rsp_inst;
        end
    end

    // Head of FIFO drives the IF/ID outputs directly; NOP/0 when empty.
    always_comb begin
        valid_IF     = !w_empty;
        INST_IF      = c_NOP;
        PC_IF        = '0;
        if (!w_empty) begin
            INST_IF = r_buf_inst[r_rd_ptr];
            PC_IF   = r_buf_pc[r_rd_ptr];
        end
        PC_plus_4_IF = PC_IF + c_PC_STEP;
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit: memory responder with
//               programmable latency, reference FIFO scoreboard, a per-cycle
//               vector table and hand sequences for redirect/reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_inst;
    logic        stall_IF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_IF;
    logic [31:0] INST_IF;
    logic [31:0] PC_IF;
    logic [31:0] PC_plus_4_IF;

    if_fetch_unit #(
        .INST_WIDTH      (32),
        .INST_ADDR_WIDTH (32),
        .RESET_PC        (c_RESET_PC),
        .BUF_DEPTH       (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_inst  (imem_rsp_inst),
        .stall_IF       (stall_IF),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .valid_IF       (valid_IF),
        .INST_IF        (INST_IF),
        .PC_IF          (PC_IF),
        .PC_plus_4_IF   (PC_plus_4_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef struct {
        logic        stall;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    entry_t      sb_q[$];
    int          m_state;      // 0 idle, 1 wait, 2 drop
    logic [31:0] m_fetch;
    logic [31:0] m_req_pc;
    bit          mem_busy;
    int          mem_left;
    int          mem_lat;
    logic [31:0] mem_addr;
    bit          last_fire;
    logic [31:0] last_fire_addr;
    bit          last_valid;
    logic [31:0] last_pc;
    logic [31:0] last_pc4;
    logic [31:0] last_inst;
    vec_t        tbl[16];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, update model, then drive memory response.
    task automatic cycle();
        bit exp_rv;
        bit fire;
        @(negedge clk);
        if (sb_q.size() != 0) begin
            check("sb_valid", {31'd0, valid_IF}, 32'd1);
            check("sb_pc", PC_IF, sb_q[0].pc);
            check("sb_inst", INST_IF, sb_q[0].inst);
            check("sb_pc4", PC_plus_4_IF, sb_q[0].pc + 32'd4);
        end else begin
            check("sb_valid_empty", {31'd0, valid_IF}, 32'd0);
            check("sb_pc_empty", PC_IF, 32'd0);
            check("sb_inst_empty", INST_IF, c_NOP);
        end
        exp_rv = (m_state == 0) && (sb_q.size() < 2) && !redirect_valid;
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch);

        last_fire      = imem_req_valid && imem_req_ready;
        last_fire_addr = imem_req_addr;
        last_valid     = valid_IF;
        last_pc        = PC_IF;
        last_pc4       = PC_plus_4_IF;
        last_inst      = INST_IF;

        if (imem_rsp_valid) mem_busy = 1'b0;
        if (imem_req_valid && imem_req_ready) begin
            check("single_outstanding", {31'd0, mem_busy}, 32'd0);
            mem_busy = 1'b1;
            mem_left = mem_lat;
            mem_addr = imem_req_addr;
        end

        fire = exp_rv && imem_req_ready;
        if (redirect_valid) begin
            sb_q.delete();
            m_fetch = redirect_pc & ~32'd3;
            if (m_state != 0) m_state = imem_rsp_valid ? 0 : 2;
        end else begin
            if (sb_q.size() != 0 && !stall_IF) void'(sb_q.pop_front());
            case (m_state)
                0: if (fire) begin
                    m_req_pc = m_fetch;
                    m_fetch  = m_fetch + 32'd4;
                    m_state  = 1;
                end
                1: if (imem_rsp_valid) begin
                    sb_q.push_back('{m_req_pc, mem_f(m_req_pc)});
                    m_state = 0;
                end
                default: if (imem_rsp_valid) m_state = 0;
            endcase
        end

        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_inst  = 32'hDEAD_BEEF;
        if (mem_busy) begin
            mem_left--;
            if (mem_left == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_inst  = mem_f(mem_addr);
            end
        end
    endtask

    // Reset for one edge; reset outputs are checked while rst is still high.
    task automatic do_reset(input bit chk);
        rst            = 1'b1;
        stall_IF       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_inst  = 32'hDEAD_BEEF;
        mem_busy       = 1'b0;
        @(posedge clk);
        #2;
        if (chk) begin
            check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("rst_valid_IF", {31'd0, valid_IF}, 32'd0);
            check("rst_INST_IF", INST_IF, c_NOP);
            check("rst_PC_IF", PC_IF, 32'd0);
            check("rst_PC_plus_4", PC_plus_4_IF, 32'd4);
        end
        sb_q.delete();
        m_state  = 0;
        m_fetch  = c_RESET_PC;
        m_req_pc = '0;
        rst      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Per-cycle vectors: 1-cycle memory, then stall held 6 cycles and released.
        tbl = '{
            '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0  },
            '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0  },
            '{1'b0, 1'b1, 32'h104, 1'b1, 32'h100},
            '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0  },
            '{1'b0, 1'b1, 32'h108, 1'b1, 32'h104},
            '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0  },
            '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h108},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108},
            '{1'b0, 1'b1, 32'h110, 1'b1, 32'h10C},
            '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0  },
            '{1'b0, 1'b1, 32'h114, 1'b1, 32'h110}
        };

        mem_lat = 1;
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            stall_IF = tbl[i].stall;
            #1;
            check("tbl_req_valid", {31'd0, imem_req_valid}, {31'd0, tbl[i].exp_rv});
            if (tbl[i].exp_rv) check("tbl_req_addr", imem_req_addr, tbl[i].exp_addr);
            check("tbl_valid_IF", {31'd0, valid_IF}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                check("tbl_PC_IF", PC_IF, tbl[i].exp_pc);
                check("tbl_INST_IF", INST_IF, mem_f(tbl[i].exp_pc));
                check("tbl_PC_plus_4", PC_plus_4_IF, tbl[i].exp_pc + 32'd4);
            end
            cycle();
        end

        // Redirect while waiting on 0x108 with a 3-cycle memory.
        mem_lat = 3;
        do_reset(1'b0);
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (last_fire && last_fire_addr == 32'h108) break;
        end
        check("redir_wait_fire_108", last_fire_addr, 32'h108);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("redir_valid_cleared", {31'd0, valid_IF}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (last_fire) break;
        end
        check("redir_next_req", last_fire_addr, 32'h2000);
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (last_valid) break;
        end
        check("redir_PC_IF", last_pc, 32'h2000);
        check("redir_INST_IF", last_inst, mem_f(32'h2000));

        // Redirect coinciding with a response and a would-be pop.
        mem_lat = 2;
        do_reset(1'b0);
        stall_IF = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (imem_rsp_valid && valid_IF) break;
        end
        check("coinc_setup", {30'd0, imem_rsp_valid, valid_IF}, 32'd3);
        stall_IF       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("coinc_empty", {31'd0, valid_IF}, 32'd0);
        check("coinc_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("coinc_req_addr", imem_req_addr, 32'h3000);
        for (int k = 0; k < 6; k++) cycle();

        // Memory not ready for 4 cycles, then 3-cycle latency.
        mem_lat = 3;
        do_reset(1'b0);
        imem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        #1;
        check("ready_low_valid", {31'd0, imem_req_valid}, 32'd1);
        check("ready_low_addr", imem_req_addr, c_RESET_PC);
        imem_req_ready = 1'b1;
        cycle();
        for (int k = 0; k < 2; k++) begin
            #1;
            check("lat3_no_req", {31'd0, imem_req_valid}, 32'd0);
            cycle();
        end
        for (int k = 0; k < 12; k++) cycle();

        // PC wrap at the top of the address space.
        mem_lat = 1;
        do_reset(1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (last_fire) break;
        end
        check("wrap_first_req", last_fire_addr, 32'hFFFF_FFFC);
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (last_fire) break;
        end
        check("wrap_next_req", last_fire_addr, 32'h0000_0000);
        check("wrap_PC_IF", last_pc, 32'hFFFF_FFFC);
        check("wrap_PC_plus_4", last_pc4, 32'h0000_0000);

        // Reset asserted while a request is outstanding.
        mem_lat = 3;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (last_fire) break;
        end
        cycle();
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
